// File: rtl/sound_sequencer.sv
// Speaker arbiter: latches game sound events, plays one fixed-priority tone at a time
// (square wave for DUR cycles, then GAP of silence); a win plays a three-note jingle.
module sound_sequencer #(
  parameter int WALL_HALF = 113636,
  parameter int HIT_HALF  = 56818,
  parameter int GOAL_HALF = 28409,
  parameter int DUR       = 5000000,
  parameter int GAP       = 1250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       wall,
  input  logic       goal,
  input  logic       p1_win,
  input  logic       p2_win,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [2:0] active,
  output logic [1:0] note_idx
);

  typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;

  localparam logic [2:0] SND_NONE = 3'd0;
  localparam logic [2:0] SND_WALL = 3'd1;
  localparam logic [2:0] SND_HIT  = 3'd2;
  localparam logic [2:0] SND_GOAL = 3'd3;
  localparam logic [2:0] SND_WIN  = 3'd4;

  localparam logic [23:0] WALL_M1 = 24'(WALL_HALF - 1);
  localparam logic [23:0] HIT_M1  = 24'(HIT_HALF - 1);
  localparam logic [23:0] GOAL_M1 = 24'(GOAL_HALF - 1);
  localparam logic [23:0] DUR_M1  = 24'(DUR - 1);
  localparam logic [23:0] GAP_M1  = 24'(GAP - 1);

  state_t      r_state;
  logic        r_speaker;
  logic        r_busy;
  logic [2:0]  r_active;
  logic [1:0]  r_note_idx;
  logic [23:0] r_half_cnt;
  logic [23:0] r_dur_cnt;
  logic [23:0] r_gap_cnt;
  logic        r_pend_wall;
  logic        r_pend_hit;
  logic        r_pend_goal;
  logic        r_pend_win;
  logic        r_win_d;

  logic        w_win_lvl;
  logic        w_win_req;
  logic        w_any_pend;
  logic [2:0]  w_grant;
  logic        w_grant_now;
  logic        w_preempt;
  logic [23:0] w_half_m1;
  logic        w_clr_wall;
  logic        w_clr_hit;
  logic        w_clr_goal;
  logic        w_clr_win;

  assign w_win_lvl  = p1_win | p2_win;
  assign w_win_req  = w_win_lvl & ~r_win_d;
  assign w_any_pend = r_pend_wall | r_pend_hit | r_pend_goal | r_pend_win;

  always_comb begin
    w_grant = SND_NONE;
    if (r_pend_win)       w_grant = SND_WIN;
    else if (r_pend_goal) w_grant = SND_GOAL;
    else if (r_pend_hit)  w_grant = SND_HIT;
    else if (r_pend_wall) w_grant = SND_WALL;
  end

  assign w_grant_now = (r_state == S_IDLE) && w_any_pend;
  // Only a win may cut another sound short; a win never restarts itself.
  assign w_preempt   = r_pend_win && (r_state != S_IDLE) && (r_active != SND_WIN);

  assign w_clr_win  = (w_grant_now && (w_grant == SND_WIN)) || w_preempt;
  assign w_clr_goal = w_grant_now && (w_grant == SND_GOAL);
  assign w_clr_hit  = w_grant_now && (w_grant == SND_HIT);
  assign w_clr_wall = w_grant_now && (w_grant == SND_WALL);

  // Jingle walks the tones from low to high pitch.
  always_comb begin
    w_half_m1 = WALL_M1;
    case (r_active)
      SND_WALL: w_half_m1 = WALL_M1;
      SND_HIT:  w_half_m1 = HIT_M1;
      SND_GOAL: w_half_m1 = GOAL_M1;
      SND_WIN: begin
        case (r_note_idx)
          2'd0:    w_half_m1 = WALL_M1;
          2'd1:    w_half_m1 = HIT_M1;
          default: w_half_m1 = GOAL_M1;
        endcase
      end
      default:  w_half_m1 = WALL_M1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_speaker   <= 1'b0;
      r_busy      <= 1'b0;
      r_active    <= SND_NONE;
      r_note_idx  <= 2'd0;
      r_half_cnt  <= 24'd0;
      r_dur_cnt   <= 24'd0;
      r_gap_cnt   <= 24'd0;
      r_pend_wall <= 1'b0;
      r_pend_hit  <= 1'b0;
      r_pend_goal <= 1'b0;
      r_pend_win  <= 1'b0;
      r_win_d     <= 1'b0;
    end else if (mute) begin
      // Keep tracking the win level so a win that rose while muted is not replayed.
      r_win_d     <= w_win_lvl;
      r_state     <= S_IDLE;
      r_speaker   <= 1'b0;
      r_busy      <= 1'b0;
      r_active    <= SND_NONE;
      r_note_idx  <= 2'd0;
      r_half_cnt  <= 24'd0;
      r_dur_cnt   <= 24'd0;
      r_gap_cnt   <= 24'd0;
      r_pend_wall <= 1'b0;
      r_pend_hit  <= 1'b0;
      r_pend_goal <= 1'b0;
      r_pend_win  <= 1'b0;
    end else begin
      r_win_d     <= w_win_lvl;
      // A new request landing on its own grant edge survives the clear.
      r_pend_wall <= (r_pend_wall & ~w_clr_wall) | wall;
      r_pend_hit  <= (r_pend_hit  & ~w_clr_hit)  | hit;
      r_pend_goal <= (r_pend_goal & ~w_clr_goal) | goal;
      r_pend_win  <= (r_pend_win  & ~w_clr_win)  | w_win_req;

      if (w_grant_now || w_preempt) begin
        r_state    <= S_TONE;
        r_busy     <= 1'b1;
        r_active   <= w_preempt ? SND_WIN : w_grant;
        r_speaker  <= 1'b1;
        r_half_cnt <= 24'd0;
        r_dur_cnt  <= 24'd0;
        r_note_idx <= 2'd0;
      end else begin
        case (r_state)
          S_TONE: begin
            r_dur_cnt <= r_dur_cnt + 24'd1;
            if (r_dur_cnt == DUR_M1) begin
              r_speaker <= 1'b0;
              r_state   <= S_GAP;
              r_gap_cnt <= 24'd0;
            end else if (r_half_cnt == w_half_m1) begin
              r_speaker  <= ~r_speaker;
              r_half_cnt <= 24'd0;
            end else begin
              r_half_cnt <= r_half_cnt + 24'd1;
            end
          end
          S_GAP: begin
            r_speaker <= 1'b0;
            r_gap_cnt <= r_gap_cnt + 24'd1;
            if (r_gap_cnt == GAP_M1) begin
              if ((r_active == SND_WIN) && (r_note_idx < 2'd2)) begin
                r_state    <= S_TONE;
                r_note_idx <= r_note_idx + 2'd1;
                r_speaker  <= 1'b1;
                r_half_cnt <= 24'd0;
                r_dur_cnt  <= 24'd0;
              end else begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_active   <= SND_NONE;
                r_note_idx <= 2'd0;
              end
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_speaker <= 1'b0;
          end
        endcase
      end
    end
  end

  assign speaker  = r_speaker;
  assign busy     = r_busy;
  assign active   = r_active;
  assign note_idx = r_note_idx;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with short tones (HIT=4, WALL=8, GOAL=2, DUR=32, GAP=8).
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       rst, hit, wall, goal, p1_win, p2_win, mute;
  logic       speaker, busy;
  logic [2:0] active;
  logic [1:0] note_idx;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  localparam logic [6:0] D_NONE = 7'b0000000;
  localparam logic [6:0] D_HIT  = 7'b0000001;
  localparam logic [6:0] D_WALL = 7'b0000010;
  localparam logic [6:0] D_GOAL = 7'b0000100;
  localparam logic [6:0] D_P1   = 7'b0001000;
  localparam logic [6:0] D_P2   = 7'b0010000;
  localparam logic [6:0] D_MUTE = 7'b0100000;
  localparam logic [6:0] D_RST  = 7'b1000000;

  sound_sequencer #(
    .WALL_HALF(8), .HIT_HALF(4), .GOAL_HALF(2), .DUR(32), .GAP(8)
  ) dut (
    .clk(clk), .rst(rst), .hit(hit), .wall(wall), .goal(goal),
    .p1_win(p1_win), .p2_win(p2_win), .mute(mute),
    .speaker(speaker), .busy(busy), .active(active), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         scn;
    int         cyc;
    bit         is_chk;
    logic [6:0] drv;
    bit         chk_sp;
    logic       exp_sp;
    logic       exp_busy;
    logic [2:0] exp_act;
    logic [1:0] exp_note;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_drv(int s, int c, logic [6:0] d);
    vec_t v;
    v.scn = s; v.cyc = c; v.is_chk = 1'b0; v.drv = d;
    v.chk_sp = 1'b0; v.exp_sp = 1'b0; v.exp_busy = 1'b0; v.exp_act = 3'd0; v.exp_note = 2'd0;
    vecs.push_back(v);
  endfunction

  function automatic void add_chk(int s, int c, logic b, logic [2:0] a, logic [1:0] n,
                                  bit cs, logic sp);
    vec_t v;
    v.scn = s; v.cyc = c; v.is_chk = 1'b1; v.drv = D_NONE;
    v.chk_sp = cs; v.exp_sp = sp; v.exp_busy = b; v.exp_act = a; v.exp_note = n;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    hit  = 1'b0;
    wall = 1'b0;
    goal = 1'b0;
  endtask

  task automatic start_scn();
    {rst, mute, p2_win, p1_win, goal, wall, hit} = D_RST;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic cmp(string name, logic [7:0] act_v, logic [7:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic run_scn(int s);
    int last;
    last = 0;
    foreach (vecs[i]) if (vecs[i].scn == s && vecs[i].cyc > last) last = vecs[i].cyc;
    start_scn();
    for (int c = 0; c <= last; c++) begin
      foreach (vecs[i]) begin
        if (vecs[i].scn == s && vecs[i].cyc == c && vecs[i].is_chk) begin
          cmp($sformatf("s%0d_c%0d_busy", s, c), {7'd0, busy}, {7'd0, vecs[i].exp_busy});
          cmp($sformatf("s%0d_c%0d_active", s, c), {5'd0, active}, {5'd0, vecs[i].exp_act});
          cmp($sformatf("s%0d_c%0d_note", s, c), {6'd0, note_idx}, {6'd0, vecs[i].exp_note});
          if (vecs[i].chk_sp)
            cmp($sformatf("s%0d_c%0d_speaker", s, c), {7'd0, speaker}, {7'd0, vecs[i].exp_sp});
          $display("scn %0d cyc %0d: busy=%b active=%b note=%0d speaker=%b",
                   s, c, busy, active, note_idx, speaker);
        end
      end
      foreach (vecs[i])
        if (vecs[i].scn == s && vecs[i].cyc == c && !vecs[i].is_chk)
          {rst, mute, p2_win, p1_win, goal, wall, hit} = vecs[i].drv;
      step();
    end
  endtask

  initial begin
    {rst, mute, p2_win, p1_win, goal, wall, hit} = D_RST;

    // 1: single hit tone
    add_drv(1, 10, D_HIT);
    add_chk(1, 0,  1'b0, 3'd0, 2'd0, 1, 1'b0);
    add_chk(1, 11, 1'b0, 3'd0, 2'd0, 1, 1'b0);
    add_chk(1, 12, 1'b1, 3'd2, 2'd0, 1, 1'b1);
    add_chk(1, 15, 1'b1, 3'd2, 2'd0, 1, 1'b1);
    add_chk(1, 16, 1'b1, 3'd2, 2'd0, 1, 1'b0);
    add_chk(1, 20, 1'b1, 3'd2, 2'd0, 1, 1'b1);
    add_chk(1, 43, 1'b1, 3'd2, 2'd0, 1, 1'b0);
    add_chk(1, 44, 1'b1, 3'd2, 2'd0, 1, 1'b0);
    add_chk(1, 51, 1'b1, 3'd2, 2'd0, 1, 1'b0);
    add_chk(1, 52, 1'b0, 3'd0, 2'd0, 1, 1'b0);

    // 2: wall granted alone, then goal before hit, one IDLE cycle between sounds
    add_drv(2, 10, D_WALL);
    add_drv(2, 11, D_HIT);
    add_drv(2, 12, D_GOAL);
    add_chk(2, 12, 1'b1, 3'd1, 2'd0, 1, 1'b1);
    add_chk(2, 51, 1'b1, 3'd1, 2'd0, 0, 1'b0);
    add_chk(2, 52, 1'b0, 3'd0, 2'd0, 1, 1'b0);
    add_chk(2, 53, 1'b1, 3'd3, 2'd0, 1, 1'b1);
    add_chk(2, 54, 1'b1, 3'd3, 2'd0, 1, 1'b1);
    add_chk(2, 55, 1'b1, 3'd3, 2'd0, 1, 1'b0);
    add_chk(2, 92, 1'b1, 3'd3, 2'd0, 0, 1'b0);
    add_chk(2, 93, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    add_chk(2, 94, 1'b1, 3'd2, 2'd0, 1, 1'b1);
    add_chk(2, 133, 1'b1, 3'd2, 2'd0, 0, 1'b0);
    add_chk(2, 134, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    add_chk(2, 135, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    add_chk(2, 140, 1'b0, 3'd0, 2'd0, 0, 1'b0);

    // 3: win preempts hit, three-note jingle
    add_drv(3, 10, D_HIT);
    add_drv(3, 20, D_P1);
    add_chk(3, 21, 1'b1, 3'd2, 2'd0, 0, 1'b0);
    add_chk(3, 22, 1'b1, 3'd4, 2'd0, 1, 1'b1);
    add_chk(3, 29, 1'b1, 3'd4, 2'd0, 1, 1'b1);
    add_chk(3, 30, 1'b1, 3'd4, 2'd0, 1, 1'b0);
    add_chk(3, 61, 1'b1, 3'd4, 2'd0, 1, 1'b0);
    add_chk(3, 62, 1'b1, 3'd4, 2'd1, 1, 1'b1);
    add_chk(3, 65, 1'b1, 3'd4, 2'd1, 1, 1'b1);
    add_chk(3, 66, 1'b1, 3'd4, 2'd1, 1, 1'b0);
    add_chk(3, 102, 1'b1, 3'd4, 2'd2, 1, 1'b1);
    add_chk(3, 103, 1'b1, 3'd4, 2'd2, 1, 1'b1);
    add_chk(3, 104, 1'b1, 3'd4, 2'd2, 1, 1'b0);
    add_chk(3, 141, 1'b1, 3'd4, 2'd2, 0, 1'b0);
    add_chk(3, 142, 1'b0, 3'd0, 2'd0, 1, 1'b0);
    add_chk(3, 150, 1'b0, 3'd0, 2'd0, 0, 1'b0);

    // 4: repeated hits collapse into one extra sound
    add_drv(4, 10, D_HIT);
    add_drv(4, 15, D_HIT);
    add_drv(4, 20, D_HIT);
    add_chk(4, 12, 1'b1, 3'd2, 2'd0, 0, 1'b0);
    add_chk(4, 52, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    add_chk(4, 53, 1'b1, 3'd2, 2'd0, 0, 1'b0);
    add_chk(4, 92, 1'b1, 3'd2, 2'd0, 0, 1'b0);
    add_chk(4, 93, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    add_chk(4, 94, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    add_chk(4, 120, 1'b0, 3'd0, 2'd0, 0, 1'b0);

    // 5: mute flushes the tone and the pending goal
    add_drv(5, 10, D_HIT);
    add_drv(5, 14, D_GOAL);
    add_drv(5, 25, D_MUTE);
    add_drv(5, 30, D_NONE);
    add_chk(5, 20, 1'b1, 3'd2, 2'd0, 0, 1'b0);
    add_chk(5, 25, 1'b1, 3'd2, 2'd0, 0, 1'b0);
    add_chk(5, 26, 1'b0, 3'd0, 2'd0, 1, 1'b0);
    add_chk(5, 31, 1'b0, 3'd0, 2'd0, 1, 1'b0);
    add_chk(5, 32, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    add_chk(5, 53, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    add_chk(5, 60, 1'b0, 3'd0, 2'd0, 0, 1'b0);

    // 6: reset mid-tone with p2_win held high, jingle follows the post-reset edge
    add_drv(6, 10, D_HIT);
    add_drv(6, 30, D_RST | D_P2);
    add_drv(6, 31, D_P2);
    add_chk(6, 29, 1'b1, 3'd2, 2'd0, 0, 1'b0);
    add_chk(6, 31, 1'b0, 3'd0, 2'd0, 1, 1'b0);
    add_chk(6, 33, 1'b1, 3'd4, 2'd0, 1, 1'b1);
    add_chk(6, 73, 1'b1, 3'd4, 2'd1, 1, 1'b1);

    // 7: request coinciding with its grant-clear stays pending
    add_drv(7, 10, D_HIT);
    add_drv(7, 11, D_HIT);
    add_chk(7, 12, 1'b1, 3'd2, 2'd0, 0, 1'b0);
    add_chk(7, 52, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    add_chk(7, 53, 1'b1, 3'd2, 2'd0, 0, 1'b0);

    for (int s = 1; s <= 7; s++) run_scn(s);

    // Full hit-tone waveform, cycle by cycle
    start_scn();
    while (cyc < 10) step();
    hit = 1'b1;
    step();
    for (int c = 11; c <= 55; c++) begin
      logic exp_sp;
      exp_sp = (c >= 12 && c <= 43) ? (((c - 12) / 4) % 2 == 0) : 1'b0;
      cmp($sformatf("wave_c%0d_speaker", c), {7'd0, speaker}, {7'd0, exp_sp});
      step();
    end
    $display("waveform scan done at cyc %0d", cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
